uart_tx_sched: RTL
==================

# uart_tx_sched

Transmit scheduler sitting between several on-chip byte producers and the `uart` Wishbone slave. After reset it configures the UART (line control, control register) over Wishbone, then round-robin arbitrates among N requesters. It polls the UART flag register for TX FIFO space and writes each granted byte to the data register. It is the sole Wishbone master on the UART's transmit path.

## Interface
Parameters:
- `N_REQ`, 4, number of byte requesters (2..8)
- `UART_BASE`, 32'h1600_0000, UART base address; bits [15:0] are zero
- `LCRH_INIT`, 8'h70, value written to LCRH at init (8N1, FIFO enable)
- `CR_INIT`, 8'h00, value written to CR at init (interrupts off)

Ports:
- `i_clk`  in  1  clock
- `i_rst`  in  1  reset; one clock; asynchronous, active-high
- `i_req`  in  N_REQ  per-requester byte request, held until granted
- `i_data`  in  8*N_REQ  byte for requester k at [8k+7:8k]
- `o_gnt`  out  N_REQ  one-cycle pulse: byte from requester k accepted
- `o_wb_adr`  out  32  Wishbone address
- `o_wb_sel`  out  4  byte select; always 4'hf during a cycle
- `o_wb_we`  out  1  write enable
- `o_wb_dat`  out  32  write data, {24'd0, byte}
- `o_wb_cyc`, `o_wb_stb`  out  1 each  Wishbone cycle/strobe, always equal
- `i_wb_dat`  in  32  read data
- `i_wb_ack`, `i_wb_err`  in  1 each  cycle termination
- `o_busy`  out  1  high in any state other than IDLE
- `o_err`  out  1  sticky; set by any `i_wb_err`, cleared only by reset

## Operation
- FSM states: INIT_LCRH, INIT_CR, IDLE, FR_RD, DR_WR.
- Reset: state INIT_LCRH, RR pointer 0, every output 0, `o_busy` 1 once reset releases.
- INIT_LCRH: write `LCRH_INIT` to base+0x08. On ack or err, go to INIT_CR.
- INIT_CR: write `CR_INIT` to base+0x14. On ack or err, go to IDLE.
- IDLE: if any `i_req`, select the first set bit at or after the RR pointer (modulo N_REQ). Latch the index and its byte, then go to FR_RD. Otherwise stay.
- FR_RD: read base+0x18.
  - On ack with `i_wb_dat[5]` (TXFF) = 0: go to DR_WR.
  - On ack with TXFF = 1, or on err: drop cyc/stb for one cycle, then re-read. The latched selection is kept.
- DR_WR: write the latched byte to base+0x00. On ack or err:
  - pulse `o_gnt[sel]`;
  - set RR pointer = (sel+1) mod N_REQ;
  - go to IDLE.
  - On err the byte is lost but still granted.
- Bus rules:
  - cyc/stb are asserted from state entry until the terminating ack/err cycle inclusive.
  - They are deasserted the following cycle.
  - adr/we/dat are stable throughout and 0 when cyc is low.
  - ack and err are never both expected; if both are seen, err wins for `o_err` and the transition follows ack.
- Requester withdrawal after selection: ignored. The latched byte is still sent and granted.
- The `i_req` bit for the granted index is not sampled in the `o_gnt` cycle. Re-arbitration starts in IDLE on the next cycle.

## Timing
- With an ack one cycle after stb (UART behaviour), a byte costs 5 cycles: IDLE 1, FR_RD 2, DR_WR 2.
- Init costs 4 cycles after reset release.
- `o_gnt` is coincident with the DR_WR ack cycle.
- Each TXFF=1 retry costs 3 cycles (2 read + 1 gap).
- Reset asserted mid-cycle drops cyc/stb asynchronously; the in-flight byte is never granted.

## Structure
- Package `uart_tx_sched_pkg`:
  - state enum;
  - register offsets `UART_DR`=0x00, `UART_LCRH`=0x08, `UART_CR`=0x14, `UART_FR`=0x18;
  - `FR_TXFF_BIT`=5.
- Sub-module `rr_arbiter` (N_REQ parameter): inputs req vector and pointer; outputs one-hot grant and index. Combinational.

## Test plan
- Reset release with `i_req`=0: Wishbone writes 0x70 to base+0x08, then 0x00 to base+0x14. The FSM then sits in IDLE with cyc=0 and `o_busy`=0.
- `i_req`=4'b0010, byte 0x41, slave never full: FR read, then write of 0x0000_0041 to base+0x00. `o_gnt`=4'b0010 pulses 5 cycles after the request is seen in IDLE.
- All four requests held, bytes 0xA0..0xA3: grant order 0,1,2,3,0. DR writes carry the matching bytes. No requester is granted twice before all others are granted once.
- FR returns TXFF=1 three times, then 0: exactly four FR reads with a one-cycle cyc gap between them, then one DR write. `o_gnt` fires once.
- `i_wb_err` on a DR write: `o_gnt` still pulses, `o_err`=1 and stays 1 across further traffic until `i_rst`.
- `i_rst` asserted during a DR_WR stb: cyc/stb fall in the same cycle and no `o_gnt` fires. After release, the init sequence repeats and the RR pointer is 0.

Source files
------------

// File: rtl/uart_tx_sched_pkg.sv
// uart_tx_sched_pkg: FSM states and UART register map shared by the transmit scheduler
package uart_tx_sched_pkg;
  typedef enum logic [2:0] {INIT_LCRH, INIT_CR, IDLE, FR_RD, DR_WR} state_t;
  localparam logic [15:0] UART_DR = 16'h0000;
  localparam logic [15:0] UART_LCRH = 16'h0008;
  localparam logic [15:0] UART_CR = 16'h0014;
  localparam logic [15:0] UART_FR = 16'h0018;
  localparam int FR_TXFF_BIT = 5;
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin pick of the first request at or after ptr
module rr_arbiter #(
  parameter int N_REQ = 4,
  localparam int W = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [W-1:0]     ptr,
  output logic [N_REQ-1:0] gnt,
  output logic [W-1:0]     idx
);
  always_comb begin
    gnt = '0;
    idx = '0;
    for (int i = N_REQ - 1; i >= 0; i--)
      if (req[(int'(ptr) + i) % N_REQ]) begin
        idx = W'((int'(ptr) + i) % N_REQ);
        gnt = N_REQ'(1) << idx;
      end
  end
endmodule

// File: rtl/uart_tx_sched.sv
// uart_tx_sched: configures the UART, then round-robin forwards requester bytes over Wishbone
module uart_tx_sched
  import uart_tx_sched_pkg::*;
#(
  parameter int          N_REQ     = 4,
  parameter logic [31:0] UART_BASE = 32'h1600_0000,
  parameter logic [7:0]  LCRH_INIT = 8'h70,
  parameter logic [7:0]  CR_INIT   = 8'h00
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic [N_REQ-1:0]   i_req,
  input  logic [8*N_REQ-1:0] i_data,
  output logic [N_REQ-1:0]   o_gnt,
  output logic [31:0]        o_wb_adr,
  output logic [3:0]         o_wb_sel,
  output logic               o_wb_we,
  output logic [31:0]        o_wb_dat,
  output logic               o_wb_cyc,
  output logic               o_wb_stb,
  input  logic [31:0]        i_wb_dat,
  input  logic               i_wb_ack,
  input  logic               i_wb_err,
  output logic               o_busy,
  output logic               o_err
);
  localparam int W = $clog2(N_REQ);
  state_t state;
  logic [W-1:0] ptr, sel, arb_idx;
  logic [N_REQ-1:0] arb_gnt;
  logic [7:0] byte_q;
  logic [15:0] off;
  logic gap, err_q, cyc, term, txff, unused_dat;
  rr_arbiter #(.N_REQ(N_REQ)) u_arb (
    .req(i_req),
    .ptr(ptr),
    .gnt(arb_gnt),
    .idx(arb_idx)
  );
  assign unused_dat = ^i_wb_dat;
  // Bus outputs decode straight from state so cyc is up on state entry and drops with reset.
  always_comb begin
    cyc = !i_rst && state != IDLE && !gap;
    term = cyc && (i_wb_ack || i_wb_err);
    txff = i_wb_dat[FR_TXFF_BIT];
    off = state == INIT_LCRH ? UART_LCRH : state == INIT_CR ? UART_CR : state == FR_RD ? UART_FR : UART_DR;
    o_wb_cyc = cyc;
    o_wb_stb = cyc;
    o_wb_sel = cyc ? 4'hf : 4'h0;
    o_wb_we = cyc && state != FR_RD;
    o_wb_adr = cyc ? UART_BASE | {16'd0, off} : 32'd0;
    o_wb_dat = !o_wb_we ? 32'd0 : {24'd0, state == INIT_LCRH ? LCRH_INIT : state == INIT_CR ? CR_INIT : byte_q};
    o_gnt = state == DR_WR && term ? N_REQ'(1) << sel : '0;
    o_busy = !i_rst && state != IDLE;
    o_err = err_q;
  end
  always_ff @(posedge i_clk or posedge i_rst)
    if (i_rst) begin
      state <= INIT_LCRH;
      ptr <= '0;
      sel <= '0;
      byte_q <= '0;
      gap <= 1'b0;
      err_q <= 1'b0;
    end else begin
      if (i_wb_err) err_q <= 1'b1;
      gap <= 1'b0;
      case (state)
        INIT_LCRH: if (term) state <= INIT_CR;
        INIT_CR: if (term) state <= IDLE;
        IDLE:
          if (|arb_gnt) begin
            sel <= arb_idx;
            byte_q <= i_data[{arb_idx, 3'b000} +: 8];
            state <= FR_RD;
          end
        FR_RD:
          if (term) begin
            if (i_wb_ack && !txff) state <= DR_WR;
            else gap <= 1'b1;
          end
        DR_WR:
          if (term) begin
            ptr <= sel == W'(N_REQ - 1) ? '0 : sel + W'(1);
            state <= IDLE;
          end
        default: state <= IDLE;
      endcase
    end
endmodule
